// File: rtl/iir_pkg.sv
// Shared types and constants for the multi-channel time-multiplexed biquad.
package iir_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_e;

    // Tap order doubles as the coefficient-select encoding on the write port.
    localparam logic [2:0] TAP_B0 = 3'd0;
    localparam logic [2:0] TAP_B1 = 3'd1;
    localparam logic [2:0] TAP_B2 = 3'd2;
    localparam logic [2:0] TAP_A1 = 3'd3;
    localparam logic [2:0] TAP_A2 = 3'd4;
    localparam int         NTAPS  = 5;

    function automatic int acc_width(input int w);
        return 2 * w + 3;
    endfunction

    function automatic int unity_coef(input int frac);
        return 1 << frac;
    endfunction

endpackage

// File: rtl/iir_round_sat.sv
// Rounds the accumulator half toward +inf, drops FRAC bits and clips to W bits.
module iir_round_sat #(
    parameter int W    = 25,
    parameter int FRAC = 16,
    parameter int AW   = 2 * W + 3
) (
    input  logic signed [AW-1:0] acc,
    output logic signed [W-1:0]  y,
    output logic                 sat
);

    localparam logic signed [AW:0] HALF = (AW+1)'(1) << (FRAC - 1);
    localparam logic signed [AW:0] YMAX = {{(AW-W+2){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [AW:0] YMIN = {{(AW-W+2){1'b1}}, {(W-1){1'b0}}};

    logic signed [AW:0] biased;
    logic signed [AW:0] shifted;

    // One guard bit keeps the rounding add from wrapping at the accumulator extremes.
    always_comb begin
        biased  = {acc[AW-1], acc} + HALF;
        shifted = biased >>> FRAC;
        sat     = 1'b0;
        y       = shifted[W-1:0];
        if (shifted > YMAX) begin
            y   = YMAX[W-1:0];
            sat = 1'b1;
        end else if (shifted < YMIN) begin
            y   = YMIN[W-1:0];
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/iir_biquad_mc.sv
// Direct Form I biquad shared by NCH channels through a single multiplier,
// one tap per clock, with per-channel programmable coefficients.
module iir_biquad_mc
    import iir_pkg::*;
#(
    parameter int  W    = 25,
    parameter int  FRAC = 16,
    parameter int  NCH  = 2,
    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx,
    input  logic signed [W-1:0] u,
    input  logic [CHW-1:0]      ch,
    input  logic                coef_we,
    input  logic [CHW-1:0]      coef_ch,
    input  logic [2:0]          coef_sel,
    input  logic signed [W-1:0] coef_data,
    output logic                busy,
    output logic                rx_2,
    output logic signed [W-1:0] y,
    output logic [CHW-1:0]      ch_out,
    output logic                sat,
    output logic                overrun
);

    localparam int                 AW    = acc_width(W);
    localparam logic signed [W-1:0] UNITY = W'(unity_coef(FRAC));

    state_e               state, state_next;
    logic [2:0]           tap;
    logic signed [AW-1:0] acc;
    logic signed [W-1:0]  u_lat;
    logic [CHW-1:0]       ch_lat;

    logic signed [W-1:0]  coef [NCH][NTAPS];
    logic signed [W-1:0]  x1 [NCH];
    logic signed [W-1:0]  x2 [NCH];
    logic signed [W-1:0]  y1 [NCH];
    logic signed [W-1:0]  y2 [NCH];

    logic                 rx_ok;
    logic                 coef_ok;
    logic signed [W-1:0]  coef_op;
    logic signed [W-1:0]  data_op;
    logic signed [2*W-1:0] product;
    logic signed [AW-1:0] prod_ext;
    logic signed [W-1:0]  y_rs;
    logic                 sat_rs;

    assign rx_ok   = rx && (32'(ch) < NCH);
    assign coef_ok = coef_we && !rx && (32'(coef_ch) < NCH) && (coef_sel <= TAP_A2);

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (rx_ok) state_next = MAC;
            MAC:     if (tap == TAP_A2) state_next = OUT;
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // Single read port into the register files, steered by the current tap.
    always_comb begin
        coef_op = coef[ch_lat][0];
        data_op = u_lat;
        case (tap)
            TAP_B1: begin coef_op = coef[ch_lat][1]; data_op = x1[ch_lat]; end
            TAP_B2: begin coef_op = coef[ch_lat][2]; data_op = x2[ch_lat]; end
            TAP_A1: begin coef_op = coef[ch_lat][3]; data_op = y1[ch_lat]; end
            TAP_A2: begin coef_op = coef[ch_lat][4]; data_op = y2[ch_lat]; end
            default: begin coef_op = coef[ch_lat][0]; data_op = u_lat; end
        endcase
    end

    assign product  = coef_op * data_op;
    assign prod_ext = {{(AW-2*W){product[2*W-1]}}, product};

    iir_round_sat #(.W(W), .FRAC(FRAC), .AW(AW)) u_round_sat (
        .acc (acc),
        .y   (y_rs),
        .sat (sat_rs)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            tap     <= TAP_B0;
            acc     <= '0;
            u_lat   <= '0;
            ch_lat  <= '0;
            rx_2    <= 1'b0;
            overrun <= 1'b0;
            y       <= '0;
            ch_out  <= '0;
            sat     <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                x1[c] <= '0;
                x2[c] <= '0;
                y1[c] <= '0;
                y2[c] <= '0;
                for (int k = 0; k < NTAPS; k++) coef[c][k] <= '0;
                coef[c][0] <= UNITY;
            end
        end else begin
            rx_2    <= 1'b0;
            overrun <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_ok) begin
                        u_lat  <= u;
                        ch_lat <= ch;
                        acc    <= '0;
                        tap    <= TAP_B0;
                    end else if (coef_ok) begin
                        for (int k = 0; k < NTAPS; k++)
                            if (coef_sel == 3'(k)) coef[coef_ch][k] <= coef_data;
                    end
                end
                MAC: begin
                    acc     <= (tap == TAP_A1 || tap == TAP_A2) ? acc - prod_ext : acc + prod_ext;
                    tap     <= tap + 3'd1;
                    overrun <= rx_ok;
                end
                OUT: begin
                    y              <= y_rs;
                    sat            <= sat_rs;
                    ch_out         <= ch_lat;
                    rx_2           <= 1'b1;
                    overrun        <= rx_ok;
                    x2[ch_lat]     <= x1[ch_lat];
                    x1[ch_lat]     <= u_lat;
                    y2[ch_lat]     <= y1[ch_lat];
                    y1[ch_lat]     <= y_rs;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/iir_biquad_mc.md
# iir_biquad_mc

Parametrised, time-multiplexed second-order IIR filter (Direct Form I biquad) serving NCH independent channels through one shared multiplier. It is the next-generation replacement for the fixed-coefficient single-channel high-pass stages. Coefficients are run-time programmable per channel, and every result is rounded and saturated. It keeps the existing rx / rx_2 strobe handshake, so the audio sample path and the file-driven benches plug in unchanged.

## Interface
- W, 25: sample and coefficient width, signed two's complement
- FRAC, 16: fractional bits of coefficients (Q(W-FRAC).FRAC)
- NCH, 2: number of channels; CHW = max(1, clog2(NCH))
- clk  in  1  system clock; one clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- rx  in  1  one-cycle sample strobe; u and ch valid while high
- u  in  W  input sample
- ch  in  CHW  channel of u
- coef_we  in  1  coefficient write strobe
- coef_ch  in  CHW  channel to write
- coef_sel  in  3  0=b0, 1=b1, 2=b2, 3=a1, 4=a2; 5-7 ignored
- coef_data  in  W  coefficient value
- busy  out  1  computation in progress
- rx_2  out  1  one-cycle result strobe
- y  out  W  filtered sample, held until next rx_2
- ch_out  out  CHW  channel of y
- sat  out  1  y was clipped; valid with rx_2, held with y
- overrun  out  1  one-cycle pulse: rx dropped because busy

## Operation
- Equation per channel: y[n] = b0·u[n] + b1·u[n-1] + b2·u[n-2] − a1·y[n-1] − a2·y[n-2].
- Per-channel state: x1, x2, y1, y2 (W each) and 5 coefficients.
- FSM states:
  - IDLE: rx=1 latches u and ch, clears the accumulator, sets tap=0, goes to MAC.
  - MAC: one product per cycle, in tap order b0·u, b1·x1, b2·x2, −a1·y1, −a2·y2. After tap 4, go to OUT.
  - OUT: write y, ch_out and sat; pulse rx_2; shift history (x2←x1, x1←u, y2←y1, y1←y); go to IDLE.
- Arithmetic:
  - Products are 2W bits; the accumulator is 2W+3 bits.
  - Result = (acc + 2^(FRAC−1)) >>> FRAC, i.e. round half toward +∞.
  - The result saturates to [−2^(W−1), 2^(W−1)−1]; sat=1 if clipped.
  - History stores the saturated y.
- rx while busy: sample dropped, overrun pulses, state untouched.
- coef_we is honoured only in IDLE with no rx in the same cycle. Otherwise the write is ignored, so coefficients never change mid-computation. A write and an rx in the same IDLE cycle: rx wins, write dropped.
- ch or coef_ch ≥ NCH: ignored. An rx with invalid ch produces no rx_2 and no overrun.
- Reset values:
  - Outputs: busy=0, rx_2=0, y=0, ch_out=0, sat=0, overrun=0.
  - All history is 0.
  - Coefficients: b0 = 2^FRAC (unity), all others 0, so the filter passes samples straight through.
- Reset asserted mid-operation aborts the computation: no rx_2, and history is not updated.

## Timing
- rx sampled at edge E0; busy=1 from after E0 until after E6.
- MAC runs on edges E1–E5; OUT on E6.
- rx_2=1 for exactly the cycle after E6, so latency is 6 clocks.
- The next rx can be accepted at E7, giving a throughput of 7 clocks per sample.
- y, ch_out and sat change only on the OUT edge.

## Structure
- Package iir_pkg holds:
  - state enum (IDLE, MAC, OUT)
  - tap-select constants B0..A2
  - accumulator width 2W+3
  - unity coefficient constant 2^FRAC
- Sub-module iir_round_sat (parameters W, FRAC, AW) is purely combinational: accumulator in, y and sat out.
- Coefficient and history arrays are register files indexed by channel, with one read port muxed by tap.

## Test plan
- Reset pass-through: after reset, rx with u=1000, ch=0 → rx_2 six cycles later, y=1000, sat=0; u=−1000 → y=−1000.
- FIR path: ch0 b0=b1=32768 (0.5); u=100 then 200 → y=50 then 150.
- Recursion: ch0 b0=65536, a1=−32768; u=1024, then 0, then 0 → y=1024, 512, 256.
- Saturation: b0=262144 (4.0); u=8388607 → y=16777215, sat=1; u=−8388608 → y=−16777216, sat=1.
- Channel isolation and overrun:
  - Program ch1 a1=−32768; interleave ch0/ch1 impulses → each channel matches its standalone response.
  - rx at E3 of a running computation → overrun pulse, no extra rx_2.
- Reset mid-MAC: rst=0 at E3 → no rx_2, y=0; the next sample behaves as the first after reset.
